// File: rtl/avalon_ram_pkg.sv
// Shared types, constants and parameter-legality helpers for the Avalon-MM RAM slave.
package avalon_ram_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD} op_t;

    localparam int CNT_W = 4;

    function automatic bit params_ok(int mem_words, logic [31:0] base, int wait_cycles);
        return (mem_words >= 4) && ((mem_words & (mem_words - 1)) == 0) &&
               (base[1:0] == 2'b00) && (wait_cycles >= 1) && (wait_cycles <= 15);
    endfunction

    // 33-bit arithmetic so a window ending exactly at 2^32 still decodes correctly
    function automatic logic in_window(logic [31:0] addr, logic [31:0] base, logic [32:0] span);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/avalon_ram_slave_store.sv
// Word-organised storage: asynchronous read, byte-enabled bus write, full-word preload.
module ram_word_store #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_idx,
    input  logic [31:0]   ld_data
);

    logic [31:0] mem_q [MEM_WORDS];

    assign rd_data = mem_q[rd_idx];

    // A preload to the same word suppresses every lane of a concurrent bus write
    always_ff @(posedge clk) begin
        if (wr_en && !(ld_en && (ld_idx == wr_idx))) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (ld_en) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

endmodule

// File: rtl/avalon_ram_slave.sv
// Avalon-MM slave RAM with fixed wait-states, range decode, error pulse and preload port.
module avalon_ram_slave
    import avalon_ram_pkg::*;
#(
    parameter int          MEM_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  address,
    input  logic                         write,
    input  logic                         read,
    output logic                         waitrequest,
    input  logic [31:0]                  writedata,
    input  logic [3:0]                   byteenable,
    output logic [31:0]                  readdata,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)+1:0] load_addr,
    input  logic [31:0]                  load_data,
    output logic                         error
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

    if (!params_ok(MEM_WORDS, BASE_ADDR, WAIT_CYCLES)) begin : g_bad_params
        $error("avalon_ram_slave: illegal MEM_WORDS/BASE_ADDR/WAIT_CYCLES");
    end

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             error_q, error_d;

    logic             hit;
    logic [31:0]      off;
    logic [AW-1:0]    idx;
    logic [31:0]      rd_word;
    logic             bus_we;
    logic             unused_load_lsb;

    // Decode works only on latched values so master changes during WAIT are ignored
    assign off             = addr_q - BASE_ADDR;
    assign idx             = AW'(off >> 2);
    assign hit             = in_window(addr_q, BASE_ADDR, SPAN);
    assign unused_load_lsb = ^load_addr[1:0];

    ram_word_store #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_store (
        .clk     (clk),
        .rd_idx  (idx),
        .rd_data (rd_word),
        .wr_en   (bus_we),
        .wr_idx  (idx),
        .wr_be   (be_q),
        .wr_data (wdata_q),
        .ld_en   (load_en),
        .ld_idx  (load_addr[AW+1:2]),
        .ld_data (load_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        readdata_d = readdata_q;
        error_d    = 1'b0;
        bus_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((read || write) && !load_en) begin
                    addr_d  = address;
                    wdata_d = writedata;
                    be_d    = byteenable;
                    op_d    = (read && write) ? OP_BAD : (read ? OP_RD : OP_WR);
                    cnt_d   = CNT_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!read && !write) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    state_d = ACK;
                    error_d = (op_q == OP_BAD) || !hit;
                    if (op_q == OP_RD) begin
                        readdata_d = hit ? rd_word : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
                bus_we  = (op_q == OP_WR) && hit;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_RD;
            readdata_q <= 32'h0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            readdata_q <= readdata_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    assign waitrequest = (state_q != ACK);
    assign readdata    = readdata_q;
    assign error       = error_q;

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Bench for avalon_ram_slave: two instances (1 and 3 wait-states) against a transaction-level model.
module tb_avalon_ram_slave;

    localparam int N0 = 1;
    localparam int N1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        read_s[2], write_s[2], load_en_s[2];
    logic [31:0] addr_s[2], wdata_s[2], ldata_s[2];
    logic [3:0]  be_s[2];
    logic [9:0]  laddr_s[2];
    logic        waitreq_s[2], error_s[2];
    logic [31:0] rdata_s[2];

    avalon_ram_slave #(.MEM_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(N0)) u_dut_w1 (
        .clk(clk), .reset(rst_n), .address(addr_s[0]), .write(write_s[0]), .read(read_s[0]),
        .waitrequest(waitreq_s[0]), .writedata(wdata_s[0]), .byteenable(be_s[0]),
        .readdata(rdata_s[0]), .load_en(load_en_s[0]), .load_addr(laddr_s[0]),
        .load_data(ldata_s[0]), .error(error_s[0])
    );

    avalon_ram_slave #(.MEM_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(N1)) u_dut_w3 (
        .clk(clk), .reset(rst_n), .address(addr_s[1]), .write(write_s[1]), .read(read_s[1]),
        .waitrequest(waitreq_s[1]), .writedata(wdata_s[1]), .byteenable(be_s[1]),
        .readdata(rdata_s[1]), .load_en(load_en_s[1]), .load_addr(laddr_s[1]),
        .load_data(ldata_s[1]), .error(error_s[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model: memory image plus, per instance, the single cycle in which the pending transfer acks
    logic [31:0] model_mem [2][256];
    int          waitn [2];
    int          ack_cyc [2];
    bit          err_exp [2];
    bit          upd_rd [2];
    logic [31:0] rd_next [2];
    logic [31:0] exp_rd [2];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic void compare_inst(int i);
        bit          at_ack;
        logic [31:0] want_rd;
        at_ack  = (rst_n === 1'b1) && (ack_cyc[i] == cyc);
        want_rd = (at_ack && upd_rd[i]) ? rd_next[i] : exp_rd[i];
        chk($sformatf("waitrequest[%0d]@%0d", i, cyc), {31'b0, waitreq_s[i]}, {31'b0, !at_ack});
        chk($sformatf("error[%0d]@%0d", i, cyc), {31'b0, error_s[i]}, {31'b0, at_ack && err_exp[i]});
        chk($sformatf("readdata[%0d]@%0d", i, cyc), rdata_s[i], want_rd);
    endfunction

    always @(negedge clk) begin
        compare_inst(0);
        compare_inst(1);
    end

    task automatic preload(input int i, input logic [31:0] a, input logic [31:0] d);
        load_en_s[i] = 1'b1;
        laddr_s[i]   = a[9:0];
        ldata_s[i]   = d;
        model_mem[i][int'(a[9:2])] = d;
        @(posedge clk); #1;
        load_en_s[i] = 1'b0;
    endtask

    // hold>0: keep load_en high (preloading ldw to the same word) that many cycles before the
    // request may be latched; collide: preload ldw to the same word on the edge leaving ACK
    task automatic xfer(input int i, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input int hold,
                        input bit collide, input logic [31:0] ldw,
                        output logic [31:0] rdv, output int nwait, output bit gerr);
        bit inr;
        bit got;
        int w;
        inr = (a < 32'd1024);
        w   = int'(a[9:2]);
        read_s[i]  = rd;
        write_s[i] = wr;
        addr_s[i]  = a;
        wdata_s[i] = wd;
        be_s[i]    = be;
        ack_cyc[i] = -1;
        if (hold > 0) begin
            load_en_s[i] = 1'b1;
            laddr_s[i]   = a[9:0];
            ldata_s[i]   = ldw;
            model_mem[i][w] = ldw;
            repeat (hold) begin
                @(posedge clk); #1;
            end
            load_en_s[i] = 1'b0;
        end
        ack_cyc[i] = cyc + waitn[i] + 1;
        err_exp[i] = (rd && wr) || !inr;
        upd_rd[i]  = rd && !wr;
        rd_next[i] = inr ? model_mem[i][w] : 32'h0;
        nwait = 0;
        got   = 1'b0;
        rdv   = '0;
        gerr  = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (waitreq_s[i] === 1'b0) begin
                got  = 1'b1;
                rdv  = rdata_s[i];
                gerr = error_s[i];
            end else begin
                nwait++;
                if (k == 1) addr_s[i] = a ^ 32'h0000_0040;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL xfer[%0d] timeout at %h: waitrequest stayed 1, expected a low cycle", i, a);
        end
        if (collide) begin
            load_en_s[i] = 1'b1;
            laddr_s[i]   = a[9:0];
            ldata_s[i]   = ldw;
        end
        @(posedge clk); #1;
        read_s[i]    = 1'b0;
        write_s[i]   = 1'b0;
        load_en_s[i] = 1'b0;
        ack_cyc[i]   = -1;
        if (upd_rd[i]) exp_rd[i] = rd_next[i];
        if (collide) begin
            model_mem[i][w] = ldw;
        end else if (wr && !rd && inr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[i][w][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdv;
        int          nw;
        bit          ge;
        waitn[0] = N0;
        waitn[1] = N1;
        for (int i = 0; i < 2; i++) begin
            read_s[i] = 0; write_s[i] = 0; load_en_s[i] = 0;
            addr_s[i] = '0; wdata_s[i] = '0; ldata_s[i] = '0; be_s[i] = '0; laddr_s[i] = '0;
            ack_cyc[i] = -1; err_exp[i] = 0; upd_rd[i] = 0; rd_next[i] = '0; exp_rd[i] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset waitrequest[%0d]", i), {31'b0, waitreq_s[i]}, 32'd1);
            chk($sformatf("reset readdata[%0d]", i), rdata_s[i], 32'h0);
            chk($sformatf("reset error[%0d]", i), {31'b0, error_s[i]}, 32'd0);
        end
        rst_n = 1'b1;

        for (int k = 0; k < 256; k++) preload(0, 32'(k * 4), 32'hA5A5_0000 + 32'(k));
        for (int k = 0; k < 8; k++) preload(1, 32'(k * 4), 32'h0);
        preload(0, 32'h04, 32'h2402_0090);
        preload(0, 32'h08, 32'h0);
        preload(0, 32'h10, 32'hCAFE_F00D);

        // Preloaded program word read back with one wait-state
        xfer(0, 1, 0, 32'h04, 0, 0, 0, 0, 0, rdv, nw, ge);
        chk("preload read value", rdv, 32'h2402_0090);
        chk("preload read wait cycles", 32'(nw), 32'd2);
        chk("preload read error", {31'b0, ge}, 32'd0);

        // Byte-lane write, then the same on the three-wait-state instance
        xfer(0, 0, 1, 32'h08, 32'hDEAD_BEEF, 4'b0101, 0, 0, 0, rdv, nw, ge);
        chk("write wait cycles n1", 32'(nw), 32'd2);
        xfer(0, 1, 0, 32'h08, 0, 0, 0, 0, 0, rdv, nw, ge);
        chk("byteenable readback n1", rdv, 32'h00AD_00EF);
        xfer(1, 0, 1, 32'h08, 32'hDEAD_BEEF, 4'b0101, 0, 0, 0, rdv, nw, ge);
        chk("write wait cycles n3", 32'(nw), 32'd4);
        xfer(1, 1, 0, 32'h08, 0, 0, 0, 0, 0, rdv, nw, ge);
        chk("read wait cycles n3", 32'(nw), 32'd4);
        chk("byteenable readback n3", rdv, 32'h00AD_00EF);

        // Out-of-range read and write, then every word must still hold its image
        xfer(0, 1, 0, 32'h400, 0, 0, 0, 0, 0, rdv, nw, ge);
        chk("oor read value", rdv, 32'h0);
        chk("oor read error", {31'b0, ge}, 32'd1);
        xfer(0, 0, 1, 32'h400, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, rdv, nw, ge);
        chk("oor write error", {31'b0, ge}, 32'd1);
        for (int k = 0; k < 256; k++) xfer(0, 1, 0, 32'(k * 4), 0, 0, 0, 0, 0, rdv, nw, ge);
        xfer(0, 1, 0, 32'h0, 0, 0, 0, 0, 0, rdv, nw, ge);
        chk("word0 after oor write", rdv, 32'hA5A5_0000);

        // read and write together: error, no memory effect, readdata held
        xfer(0, 1, 0, 32'h08, 0, 0, 0, 0, 0, rdv, nw, ge);
        xfer(0, 1, 1, 32'h0C, 32'h1234_5678, 4'b1111, 0, 0, 0, rdv, nw, ge);
        chk("rd+wr error", {31'b0, ge}, 32'd1);
        chk("rd+wr readdata held", rdv, 32'h00AD_00EF);
        xfer(0, 1, 0, 32'h0C, 0, 0, 0, 0, 0, rdv, nw, ge);
        chk("word3 after rd+wr", rdv, 32'hA5A5_0003);

        // Master drops read while the slave is stalling: no ACK cycle follows
        read_s[0] = 1'b1;
        addr_s[0] = 32'h04;
        ack_cyc[0] = -1;
        @(posedge clk); #1;
        read_s[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Bus write and preload to the same word on the same edge
        xfer(0, 0, 1, 32'h08, 32'h1111_1111, 4'b1111, 0, 1, 32'h2222_2222, rdv, nw, ge);
        xfer(0, 1, 0, 32'h08, 0, 0, 0, 0, 0, rdv, nw, ge);
        chk("collision preload wins", rdv, 32'h2222_2222);

        // Pending read blocked while load_en is held
        xfer(0, 1, 0, 32'h14, 0, 0, 3, 0, 32'h1357_9BDF, rdv, nw, ge);
        chk("read after load_en hold", rdv, 32'h1357_9BDF);
        chk("wait cycles after load_en drop", 32'(nw), 32'd2);

        // Reset during the stall of a write: nothing commits
        write_s[0] = 1'b1;
        addr_s[0]  = 32'h10;
        wdata_s[0] = 32'h0;
        be_s[0]    = 4'b1111;
        ack_cyc[0] = -1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        ack_cyc[0] = -1;
        ack_cyc[1] = -1;
        #1;
        chk("async reset waitrequest", {31'b0, waitreq_s[0]}, 32'd1);
        chk("async reset readdata", rdata_s[0], 32'h0);
        write_s[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, rdv, nw, ge);
        chk("word4 after reset mid-write", rdv, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
